// File: rtl/uart.sv
// Memory-mapped 8N1 UART slave: TX FIFO + serializer, RX synchronizer + mid-bit sampler.
// Optional interrupt output and CTRL register are built when UART_IRQ_EN is defined.
module uart #(
    parameter int          TX_FIFO_DEPTH = 8,
    parameter logic [15:0] DEFAULT_DIV   = 16'd433
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic        mem_cmd_sel,
    input  logic        mem_cmd_valid,
    input  logic        mem_cmd_wr,
    input  logic [11:0] mem_cmd_addr,
    input  logic [31:0] mem_cmd_wdata,
    output logic        mem_rsp_ready,
    output logic [31:0] mem_rsp_rdata,
    output logic        uart_txd,
    input  logic        uart_rxd
`ifdef UART_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int          AW      = $clog2(TX_FIFO_DEPTH);
    localparam logic [15:0] MIN_DIV = 16'd3;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(TX_FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // ---------------- bus decode ----------------
    logic [9:0] word;
    logic       cmd_rd, cmd_wr;
    logic       wr_data, wr_status, wr_div, rd_data;

    assign word      = mem_cmd_addr[11:2];
    assign cmd_rd    = mem_cmd_sel & mem_cmd_valid & ~mem_cmd_wr;
    assign cmd_wr    = mem_cmd_sel & mem_cmd_valid & mem_cmd_wr;
    assign wr_data   = cmd_wr & (word == 10'd0);
    assign wr_status = cmd_wr & (word == 10'd1);
    assign wr_div    = cmd_wr & (word == 10'd2);
    assign rd_data   = cmd_rd & (word == 10'd0);

    // ---------------- registers ----------------
    logic [15:0] baud_div;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_ovr, tx_ovf, rx_ferr;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            baud_div <= DEFAULT_DIV;
        end else if (wr_div) begin
            baud_div <= (mem_cmd_wdata[15:0] < MIN_DIV) ? MIN_DIV : mem_cmd_wdata[15:0];
        end
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]    fifo_mem [TX_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          tx_empty, tx_full, push_ok, tx_pop;

    assign tx_empty = (count == '0);
    assign tx_full  = (count == FULL_CNT);
    assign push_ok  = wr_data & ~tx_full;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (tx_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !tx_pop)      count <= count + 1'b1;
            else if (!push_ok && tx_pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= mem_cmd_wdata[7:0];
    end

    // ---------------- TX FSM ----------------
    // The byte in flight stays at the FIFO head until its stop bit ends,
    // so the FIFO depth bounds all accepted-but-unsent bytes.
    state_t      tx_state, tx_state_nxt;
    logic [15:0] tx_cnt, tx_cnt_nxt;
    logic [2:0]  tx_idx, tx_idx_nxt;
    logic [7:0]  tx_shift, tx_shift_nxt;
    logic        txd_nxt, tx_tick, tx_busy;

    assign tx_tick = (tx_cnt == 16'd0);
    assign tx_busy = (tx_state != S_IDLE);

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            uart_txd <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_idx   <= tx_idx_nxt;
            tx_shift <= tx_shift_nxt;
            uart_txd <= txd_nxt;
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_tick ? baud_div : tx_cnt - 16'd1;
        tx_idx_nxt   = tx_idx;
        tx_shift_nxt = tx_shift;
        tx_pop       = 1'b0;
        case (tx_state)
            S_IDLE: begin
                tx_cnt_nxt = baud_div;
                if (!tx_empty) tx_state_nxt = S_START;
            end
            S_START: begin
                if (tx_tick) begin
                    tx_state_nxt = S_DATA;
                    tx_idx_nxt   = '0;
                    tx_shift_nxt = fifo_mem[rd_ptr];
                end
            end
            S_DATA: begin
                if (tx_tick) begin
                    tx_shift_nxt = {1'b0, tx_shift[7:1]};
                    tx_idx_nxt   = tx_idx + 3'd1;
                    if (tx_idx == 3'd7) tx_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (tx_tick) begin
                    tx_pop       = 1'b1;
                    tx_state_nxt = (count > (AW+1)'(1) || push_ok) ? S_START : S_IDLE;
                end
            end
            default: tx_state_nxt = S_IDLE;
        endcase
        case (tx_state_nxt)
            S_START: txd_nxt = 1'b0;
            S_DATA:  txd_nxt = tx_shift_nxt[0];
            default: txd_nxt = 1'b1;
        endcase
    end

    // ---------------- RX synchronizer + FSM ----------------
    logic        rxd_s1, rxd_s2, rxd_prev;
    state_t      rx_state, rx_state_nxt;
    logic [15:0] rx_cnt, rx_cnt_nxt, rx_half;
    logic [16:0] half_wide;
    logic [2:0]  rx_idx, rx_idx_nxt;
    logic [7:0]  rx_shift, rx_shift_nxt;
    logic        rx_tick, rx_done, rx_bad;

    assign half_wide = ({1'b0, baud_div} + 17'd1) >> 1;
    assign rx_half   = half_wide[15:0] - 16'd1;
    assign rx_tick   = (rx_cnt == 16'd0);

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            rxd_s1   <= 1'b1;
            rxd_s2   <= 1'b1;
            rxd_prev <= 1'b1;
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
        end else begin
            rxd_s1   <= uart_rxd;
            rxd_s2   <= rxd_s1;
            rxd_prev <= rxd_s2;
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_idx   <= rx_idx_nxt;
            rx_shift <= rx_shift_nxt;
        end
    end

    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_tick ? baud_div : rx_cnt - 16'd1;
        rx_idx_nxt   = rx_idx;
        rx_shift_nxt = rx_shift;
        rx_done      = 1'b0;
        rx_bad       = 1'b0;
        case (rx_state)
            S_IDLE: begin
                rx_cnt_nxt = rx_half;
                if (rxd_prev && !rxd_s2) rx_state_nxt = S_START;
            end
            S_START: begin
                if (rx_tick) begin
                    rx_idx_nxt   = '0;
                    rx_state_nxt = rxd_s2 ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (rx_tick) begin
                    rx_shift_nxt = {rxd_s2, rx_shift[7:1]};
                    rx_idx_nxt   = rx_idx + 3'd1;
                    if (rx_idx == 3'd7) rx_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (rx_tick) begin
                    rx_done      = rxd_s2;
                    rx_bad       = ~rxd_s2;
                    rx_state_nxt = S_IDLE;
                end
            end
            default: rx_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- status ----------------
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_ovr   <= 1'b0;
            tx_ovf   <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            if (rx_done) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
            end else if (rd_data) begin
                rx_valid <= 1'b0;
            end
            // A byte landing on the same edge as a DATA read replaces the one being read.
            if (rx_done && rx_valid && !rd_data)    rx_ovr <= 1'b1;
            else if (wr_status && mem_cmd_wdata[4]) rx_ovr <= 1'b0;
            if (wr_data && tx_full)                 tx_ovf <= 1'b1;
            else if (wr_status && mem_cmd_wdata[5]) tx_ovf <= 1'b0;
            if (rx_bad)                             rx_ferr <= 1'b1;
            else if (wr_status && mem_cmd_wdata[6]) rx_ferr <= 1'b0;
        end
    end

`ifdef UART_IRQ_EN
    logic rx_ie, tx_ie;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            rx_ie <= 1'b0;
            tx_ie <= 1'b0;
            irq   <= 1'b0;
        end else begin
            if (cmd_wr && word == 10'd3) begin
                rx_ie <= mem_cmd_wdata[0];
                tx_ie <= mem_cmd_wdata[1];
            end
            irq <= (rx_valid & rx_ie) | (tx_empty & ~tx_busy & tx_ie);
        end
    end
`endif

    // ---------------- read path ----------------
    logic [31:0] rdata_mux;

    always_comb begin
        rdata_mux = '0;
        case (word)
            10'd0: rdata_mux = {23'd0, rx_valid, rx_data};
            10'd1: rdata_mux = {25'd0, rx_ferr, tx_ovf, rx_ovr, rx_valid, tx_busy, tx_full, tx_empty};
            10'd2: rdata_mux = {16'd0, baud_div};
`ifdef UART_IRQ_EN
            10'd3: rdata_mux = {30'd0, tx_ie, rx_ie};
`endif
            default: rdata_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            mem_rsp_ready <= 1'b0;
            mem_rsp_rdata <= '0;
        end else begin
            mem_rsp_ready <= cmd_rd;
            mem_rsp_rdata <= cmd_rd ? rdata_mux : 32'd0;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{mem_cmd_addr[1:0], mem_cmd_wdata[31:16], half_wide[16]};

endmodule

// File: tb/tb_uart.sv
// Directed self-checking bench for the uart slave: register access, TX framing,
// FIFO overflow, RX sampling/overrun/framing, glitch rejection and async reset.
module tb_uart;

    logic        clk = 1'b0;
    logic        reset_ = 1'b0;
    logic        sel = 1'b0, valid = 1'b0, wr = 1'b0;
    logic [11:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        txd;
    logic        rxd = 1'b1;
    logic        irq;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart dut (
        .clk           (clk),
        .reset_        (reset_),
        .mem_cmd_sel   (sel),
        .mem_cmd_valid (valid),
        .mem_cmd_wr    (wr),
        .mem_cmd_addr  (addr),
        .mem_cmd_wdata (wdata),
        .mem_rsp_ready (rsp_ready),
        .mem_rsp_rdata (rsp_rdata),
        .uart_txd      (txd),
        .uart_rxd      (rxd)
`ifdef UART_IRQ_EN
        ,
        .irq           (irq)
`endif
    );

`ifndef UART_IRQ_EN
    assign irq = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; valid = 1'b1; wr = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        sel = 1'b0; valid = 1'b0; wr = 1'b0;
    endtask

    // A missing response yields a sentinel so the caller's comparison fails.
    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] d;
        @(negedge clk);
        sel = 1'b1; valid = 1'b1; wr = 1'b0; addr = a;
        @(negedge clk);
        sel = 1'b0; valid = 1'b0;
        d = rsp_ready ? rsp_rdata : 32'hDEAD_BEEF;
        chk(tag, d, exp);
    endtask

    // Checks 4 samples per bit of start, data (LSB first) and stop.
    task automatic tx_frame(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                chk($sformatf("txd[%0h] bit%0d", b, i), {31'd0, txd}, {31'd0, f[i]});
            end
        end
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rxd = f[i];
            repeat (3) @(negedge clk);
        end
        @(negedge clk);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset state ----
        repeat (3) @(negedge clk);
        chk("rst txd", {31'd0, txd}, 32'd1);
        chk("rst rsp_ready", {31'd0, rsp_ready}, 32'd0);
        chk("rst rsp_rdata", rsp_rdata, 32'd0);
        reset_ = 1'b1;
        rd_chk("rst STATUS", 12'h004, 32'h1);
        rd_chk("rst BAUD", 12'h008, 32'd433);

        // ---- register basics ----
        bus_wr(12'h008, 32'd1);
        rd_chk("BAUD clamp", 12'h008, 32'd3);
        bus_wr(12'h008, 32'd3);
        rd_chk("unmapped rd", 12'h010, 32'd0);
        @(negedge clk);
        sel = 1'b0; valid = 1'b1; wr = 1'b0; addr = 12'h004;
        @(negedge clk);
        valid = 1'b0;
        chk("no sel no rsp", {31'd0, rsp_ready}, 32'd0);
`ifndef UART_IRQ_EN
        bus_wr(12'h00C, 32'h3);
        rd_chk("CTRL absent", 12'h00C, 32'd0);
`endif

        // ---- single TX frame ----
        bus_wr(12'h000, 32'hA5);
        tx_frame(8'hA5);
        rd_chk("STATUS after tx", 12'h004, 32'h1);

        // ---- FIFO overflow + back-to-back frames ----
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    sel = 1'b1; valid = 1'b1; wr = 1'b1; addr = 12'h000; wdata = 32'h10 + i;
                end
                @(negedge clk);
                sel = 1'b0; valid = 1'b0; wr = 1'b0;
                rd_chk("STATUS full", 12'h004, 32'h26);
            end
            begin
                repeat (2) @(negedge clk);
                for (int k = 0; k < 8; k++) tx_frame(8'(8'h10 + k));
            end
        join
        rd_chk("STATUS ovf", 12'h004, 32'h21);
        bus_wr(12'h004, 32'h20);
        rd_chk("STATUS ovf clr", 12'h004, 32'h1);

        // ---- RX ----
        rx_send(8'h3C, 1'b1);
        rd_chk("STATUS rx", 12'h004, 32'h9);
        rd_chk("DATA rx", 12'h000, 32'h13C);
        rd_chk("STATUS rx clr", 12'h004, 32'h1);
        rx_send(8'h11, 1'b1);
        rx_send(8'h22, 1'b1);
        rd_chk("STATUS ovr", 12'h004, 32'h19);
        rd_chk("DATA ovr", 12'h000, 32'h122);
        bus_wr(12'h004, 32'h10);
        rd_chk("STATUS ovr clr", 12'h004, 32'h1);

        // ---- framing error, glitch ----
        rx_send(8'h55, 1'b0);
        rd_chk("STATUS ferr", 12'h004, 32'h41);
        bus_wr(12'h004, 32'h40);
        rd_chk("STATUS ferr clr", 12'h004, 32'h1);
        @(negedge clk); rxd = 1'b0;
        @(negedge clk); rxd = 1'b1;
        repeat (10) @(negedge clk);
        rd_chk("STATUS glitch", 12'h004, 32'h1);
        rd_chk("DATA glitch", 12'h000, 32'h022);

        // ---- DATA read on the same edge a new byte completes ----
        rx_send(8'h81, 1'b1);
        fork
            rx_send(8'h44, 1'b1);
            begin
                repeat (39) @(negedge clk);
                rd_chk("DATA race", 12'h000, 32'h181);
            end
        join
        rd_chk("STATUS race", 12'h004, 32'h9);
        rd_chk("DATA race new", 12'h000, 32'h144);

        // ---- reset mid-frame ----
        bus_wr(12'h000, 32'h00);
        bus_wr(12'h000, 32'h00);
        repeat (8) @(negedge clk);
        chk("txd mid frame", {31'd0, txd}, 32'd0);
        #2 reset_ = 1'b0;
        #1 chk("txd async rst", {31'd0, txd}, 32'd1);
        @(negedge clk);
        reset_ = 1'b1;
        rd_chk("STATUS post rst", 12'h004, 32'h1);
        rd_chk("BAUD post rst", 12'h008, 32'd433);
        repeat (5) @(negedge clk);
        chk("txd idle post rst", {31'd0, txd}, 32'd1);

`ifdef UART_IRQ_EN
        // ---- interrupt ----
        chk("irq rst", {31'd0, irq}, 32'd0);
        bus_wr(12'h008, 32'd3);
        bus_wr(12'h00C, 32'h1);
        rd_chk("CTRL rd", 12'h00C, 32'h1);
        rx_send(8'h5A, 1'b1);
        chk("irq rx", {31'd0, irq}, 32'd1);
        rd_chk("DATA irq", 12'h000, 32'h15A);
        repeat (2) @(negedge clk);
        chk("irq cleared", {31'd0, irq}, 32'd0);
        bus_wr(12'h00C, 32'h2);
        repeat (2) @(negedge clk);
        chk("irq tx", {31'd0, irq}, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
